// File: rtl/or8way_unit.sv
// rtl/or8way_unit.sv - OR-reduction with registered result, sticky flag, lowest-set index and popcount
module or8way_unit #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             out_o,
    output logic             out_q_o,
    output logic             valid_o,
    output logic             sticky_o,
    output logic [IDX_W-1:0] hit_idx_o,
    output logic [CNT_W-1:0] hit_cnt_o
);

    logic [IDX_W-1:0] idx_d;
    logic [CNT_W-1:0] cnt_d;

    assign out_o = |in_i;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_d = '0;
        cnt_d = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_d = IDX_W'(i);
            end
            cnt_d = cnt_d + CNT_W'(in_i[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_q_o   <= 1'b0;
            valid_o   <= 1'b0;
            sticky_o  <= 1'b0;
            hit_idx_o <= '0;
            hit_cnt_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                out_q_o   <= out_o;
                hit_idx_o <= idx_d;
                hit_cnt_o <= cnt_d;
            end
            // Clear drops old history but still folds in a same-cycle sample.
            if (clear_i) begin
                sticky_o <= valid_i & out_o;
            end else if (valid_i) begin
                sticky_o <= sticky_o | out_o;
            end
        end
    end

endmodule

// File: tb/tb_or8way_unit.sv
// tb/tb_or8way_unit.sv - directed self-checking bench for or8way_unit
module tb_or8way_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_v;
    logic       valid;
    logic       clear;
    logic       out_c;
    logic       out_q;
    logic       valid_q;
    logic       sticky;
    logic [2:0] hit_idx;
    logic [3:0] hit_cnt;

    int n_vec = 0;
    int n_err = 0;

    or8way_unit #(.WIDTH(8)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .in_i      (in_v),
        .valid_i   (valid),
        .clear_i   (clear),
        .out_o     (out_c),
        .out_q_o   (out_q),
        .valid_o   (valid_q),
        .sticky_o  (sticky),
        .hit_idx_o (hit_idx),
        .hit_cnt_o (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_cnt(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 8; k++) c = c + {3'd0, v[k]};
        return c;
    endfunction

    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        for (int k = 0; k < 8; k++) if (v[k]) return 3'(k);
        return 3'd0;
    endfunction

    logic [7:0] comb_vec [6] = '{8'h00, 8'h01, 8'hA0, 8'hDF, 8'h00, 8'hFF};
    logic       comb_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] sticky_vec [3] = '{8'h00, 8'h01, 8'h00};
    logic       sticky_exp [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        clear = 1'b0;
        in_v  = 8'h00;
        tick();
        tick();
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_valid", 32'(valid_q), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_idx", 32'(hit_idx), 32'd0);
        check("rst_cnt", 32'(hit_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            in_v = comb_vec[i];
            #10;
            check("comb_sweep", 32'(out_c), 32'(comb_exp[i]));
        end

        in_v  = 8'hA0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("cap_out_q", 32'(out_q), 32'd1);
        check("cap_valid", 32'(valid_q), 32'd1);
        check("cap_idx", 32'(hit_idx), 32'd5);
        check("cap_cnt", 32'(hit_cnt), 32'd2);
        tick();
        check("hold_valid", 32'(valid_q), 32'd0);
        check("hold_out_q", 32'(out_q), 32'd1);
        check("hold_idx", 32'(hit_idx), 32'd5);
        check("hold_cnt", 32'(hit_cnt), 32'd2);

        in_v = 8'h00; valid = 1'b1; tick(); valid = 1'b0;
        check("zero_out_q", 32'(out_q), 32'd0);
        check("zero_idx", 32'(hit_idx), 32'd0);
        check("zero_cnt", 32'(hit_cnt), 32'd0);
        in_v = 8'hFF; valid = 1'b1; tick(); valid = 1'b0;
        check("ones_out_q", 32'(out_q), 32'd1);
        check("ones_idx", 32'(hit_idx), 32'd0);
        check("ones_cnt", 32'(hit_cnt), 32'd8);
        in_v = 8'h80; valid = 1'b1; tick(); valid = 1'b0;
        check("msb_idx", 32'(hit_idx), 32'd7);
        check("msb_cnt", 32'(hit_cnt), 32'd1);

        clear = 1'b1; tick(); clear = 1'b0;
        check("sticky_pre_clear", 32'(sticky), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_v  = sticky_vec[i];
            valid = 1'b1;
            tick();
            valid = 1'b0;
            check("sticky_acc", 32'(sticky), 32'(sticky_exp[i]));
        end
        clear = 1'b1; tick(); clear = 1'b0;
        check("sticky_clear", 32'(sticky), 32'd0);
        in_v = 8'hDF; clear = 1'b1; valid = 1'b1; tick(); clear = 1'b0; valid = 1'b0;
        check("sticky_clear_valid", 32'(sticky), 32'd1);

        in_v = 8'hFF; valid = 1'b1; rst_n = 1'b0;
        #1;
        check("rst_out_c_before", 32'(out_c), 32'd1);
        tick();
        rst_n = 1'b1; valid = 1'b0;
        check("mid_rst_out_q", 32'(out_q), 32'd0);
        check("mid_rst_valid", 32'(valid_q), 32'd0);
        check("mid_rst_sticky", 32'(sticky), 32'd0);
        check("mid_rst_idx", 32'(hit_idx), 32'd0);
        check("mid_rst_cnt", 32'(hit_cnt), 32'd0);
        check("rst_out_c_after", 32'(out_c), 32'd1);

        for (int v = 0; v < 256; v++) begin
            in_v  = 8'(v);
            valid = 1'b1;
            #1;
            check("exh_out_c", 32'(out_c), 32'(v != 0));
            tick();
            check("exh_valid", 32'(valid_q), 32'd1);
            check("exh_out_q", 32'(out_q), 32'(v != 0));
            check("exh_idx", 32'(hit_idx), 32'(ref_idx(8'(v))));
            check("exh_cnt", 32'(hit_cnt), 32'(ref_cnt(8'(v))));
        end
        valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/or8way_unit.md
Name: or8way_unit

Overview:
- 8-input OR-reduction block from the Nand2Tetris gate library, used wherever a "any bit set" flag is needed (e.g. ALU zero-flag generation, where zr = NOT out).
- Provides the classic combinational Or8Way result plus a registered copy with valid tagging.
- Also provides a sticky accumulate flag, lowest-set-bit index and set-bit count for status/debug use.

Parameters:
- WIDTH, 8, number of input bits; must be ≥2. The 8-way configuration is the reference use.
- IDX_W, $clog2(WIDTH), width of hit_idx_o.
- CNT_W, $clog2(WIDTH+1), width of hit_cnt_o.

Ports:
- clk_i  input  1  rising-edge clock
- rst_n_i  input  1  synchronous active-low reset
- in_i  input  WIDTH  operand bits
- valid_i  input  1  in_i qualifies for capture this cycle
- clear_i  input  1  clears sticky_o
- out_o  output  1  combinational OR of all in_i bits
- out_q_o  output  1  registered OR of last valid in_i
- valid_o  output  1  out_q_o/hit_* hold a fresh result (one cycle pulse)
- sticky_o  output  1  OR accumulated over all valid inputs since reset/clear
- hit_idx_o  output  IDX_W  index of lowest set bit of last valid in_i; 0 if none set
- hit_cnt_o  output  CNT_W  number of set bits in last valid in_i

Behaviour:
- out_o = in_i[0] | in_i[1] | ... | in_i[WIDTH-1].
  - Purely combinational, zero latency.
  - Unaffected by clock, reset and valid_i.
  - X-free for any defined input.
- Reset (rst_n_i low at a rising clk_i edge) drives out_q_o, valid_o, sticky_o, hit_idx_o and hit_cnt_o to 0. Reset takes priority over all other inputs.
- Registered path, 1-cycle latency:
  - On a clock edge with valid_i=1, capture OR(in_i) into out_q_o, lowest set index into hit_idx_o, popcount into hit_cnt_o, and set valid_o=1.
  - With valid_i=0: out_q_o, hit_idx_o and hit_cnt_o hold their values; valid_o=0.
- Priority encode: hit_idx_o is the smallest i with in_i[i]=1.
  - All-zero input gives hit_idx_o=0 and out_q_o=0. Use out_q_o to distinguish this from bit 0 set.
- Popcount: hit_cnt_o ranges 0..WIDTH. For an all-ones input, hit_cnt_o=WIDTH with no overflow (CNT_W sized for it).
- Sticky, per clock edge:
  - clear_i=1 and valid_i=1 together: sticky_o <= OR(in_i). Clear wins over old state, but the new sample is still accumulated.
  - clear_i=1 only: sticky_o <= 0.
  - valid_i=1 only: sticky_o <= sticky_o | OR(in_i).
  - Otherwise: hold.
- Reset mid-operation discards any pending capture. valid_o is 0 in the cycle after reset regardless of valid_i.
- No handshake backpressure: every valid_i is accepted.

Test Plan:
- Combinational sweep, each input held 10 ns: in_i=0x00 -> out_o=0; 0x01 -> 1; 0xA0 -> 1; 0xDF -> 1; 0x00 -> 0; 0xFF -> 1.
- Registered capture:
  - After reset, valid_i=1 with in_i=0xA0 -> next cycle out_q_o=1, valid_o=1, hit_idx_o=5, hit_cnt_o=2.
  - valid_i=0 the following cycle -> valid_o=0, other outputs hold.
- Boundaries:
  - in_i=0x00 valid -> out_q_o=0, hit_idx_o=0, hit_cnt_o=0.
  - in_i=0xFF valid -> hit_idx_o=0, hit_cnt_o=8.
  - in_i=0x80 valid -> hit_idx_o=7, hit_cnt_o=1.
- Sticky:
  - Valid inputs 0x00 then 0x01 then 0x00 -> sticky_o reads 0, 1, 1.
  - clear_i alone -> 0.
  - clear_i with valid 0xDF -> 1.
- Reset:
  - Assert rst_n_i=0 for one edge while valid_i=1 and in_i=0xFF -> next cycle all registered outputs 0.
  - out_o stays 1 throughout.
- Exhaustive: all 256 in_i values -> out_o=(in_i!=0); registered hit_cnt_o and hit_idx_o match a reference model.
